// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU port, the DMA port and the RAM-side signals of the memory arbiter.
//   cpu_*/dma_* : req/addr/we/byte/wdata/lock in toward the arbiter; ack/rdata back to the requester
//   mem_*       : addr/we/byte/din toward the RAM; dout is the RAM's combinational read data
//   slave  modport: the arbiter's view
//   master modport: the requesters' and the RAM's view
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic          cpu_byte;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_lock;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_we;
  logic          dma_byte;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_byte;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_byte, cpu_wdata, cpu_lock,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_addr, dma_we, dma_byte, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_we, mem_byte, mem_din,
    input  mem_dout
  );
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_byte, cpu_wdata, cpu_lock,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_addr, dma_we, dma_byte, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_we, mem_byte, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one RAM port between the CPU (port 0) and a DMA device (port 1).
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-high reset; aborts any transfer in flight without an ack
//   bus   : mem_arbiter_if.slave -- both requester handshakes plus the RAM address/control/data lines
// Each transfer is IDLE (arbitrate) -> ACC (RAM access) -> DONE (ack pulse). The CPU may lock the
// bus across a read-modify-write pair, and consecutive DMA grants are capped while the CPU waits.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int DMA_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam logic [3:0] DMAX = 4'(DMA_MAX);
  typedef enum logic [2:0] {IDLE, CPU_ACC, DMA_ACC, CPU_DONE, DMA_DONE} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          locked_q, locked_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_byte_q, mem_byte_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          grant_cpu, grant_dma;
  // The CPU wins when locked, when alone, when the DMA has used up its run, or when it is its turn.
  // A held lock keeps the DMA out even in the IDLE cycle where the lock is being released.
  assign grant_cpu = bus.cpu_req & (locked_q | ~bus.dma_req | (dcnt_q >= DMAX) | last_q);
  assign grant_dma = bus.dma_req & ~grant_cpu & ~locked_q;
  // RAM lines are loaded on the grant edge from the winner's stable inputs, so they are valid for the
  // whole ACC cycle and simply hold their values afterwards; only mem_we is dropped.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    locked_d    = locked_q;
    dcnt_d      = dcnt_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_byte_d  = mem_byte_q;
    mem_din_d   = mem_din_q;
    case (state_q)
      IDLE: begin
        locked_d = locked_q & bus.cpu_req;
        if (grant_cpu) begin
          state_d    = CPU_ACC;
          mem_addr_d = bus.cpu_addr;
          mem_we_d   = bus.cpu_we;
          mem_byte_d = bus.cpu_byte;
          mem_din_d  = bus.cpu_wdata;
        end else if (grant_dma) begin
          state_d    = DMA_ACC;
          mem_addr_d = bus.dma_addr;
          mem_we_d   = bus.dma_we;
          mem_byte_d = bus.dma_byte;
          mem_din_d  = bus.dma_wdata;
        end
      end
      CPU_ACC: begin
        state_d     = CPU_DONE;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = bus.mem_dout;
        locked_d    = bus.cpu_lock;
      end
      DMA_ACC: begin
        state_d     = DMA_DONE;
        dma_ack_d   = 1'b1;
        dma_rdata_d = bus.mem_dout;
      end
      CPU_DONE: begin
        state_d = IDLE;
        last_d  = 1'b0;
        dcnt_d  = 4'd0;
      end
      DMA_DONE: begin
        state_d  = IDLE;
        last_d   = 1'b1;
        locked_d = 1'b0;
        dcnt_d   = bus.cpu_req ? ((dcnt_q == 4'd15) ? 4'd15 : dcnt_q + 4'd1) : 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      locked_q    <= 1'b0;
      dcnt_q      <= 4'd0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      locked_q    <= locked_d;
      dcnt_q      <= dcnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_din_q   <= mem_din_d;
    end
  end
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_byte  = mem_byte_q;
  assign bus.mem_din   = mem_din_q;
endmodule
